// File: rtl/v_border_pkg.sv
// Shared types and helpers for the vertical border mask generator.
// Used by wrap_ctr and v_border_mask_genr.
package v_border_pkg;

  localparam int CTR_W = 16;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  function automatic int pad_rows(input int ker);
    return (ker - 1) / 2;
  endfunction

endpackage

// File: rtl/wrap_ctr.sv
// Column/row counter pair with wrap at the configured lengths.
// Synchronous clear takes priority over enable.
module wrap_ctr
  import v_border_pkg::*;
#(
  parameter logic [CTR_W-1:0] COL_LEN = 16'd520,
  parameter logic [CTR_W-1:0] ROW_LEN = 16'd520
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic [CTR_W-1:0] col,
  output logic [CTR_W-1:0] row,
  output logic             last_col,
  output logic             last_row
);

  assign last_col = (col == COL_LEN - CTR_W'(1));
  assign last_row = (row == ROW_LEN - CTR_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (clr) begin
      col <= '0;
      row <= '0;
    end else if (en) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + CTR_W'(1);
      end else begin
        col <= col + CTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/v_border_mask_genr.sv
// Vertical border mask generator: fill, run and flush of padding rows.
// Define VBORDER_FRAME_CNT_EN to add the frame_cnt output.
module v_border_mask_genr
  import v_border_pkg::*;
#(
  parameter logic [CTR_W-1:0] HIM_LEN   = 16'd520,
  parameter logic [CTR_W-1:0] VIM_LEN   = 16'd520,
  parameter int               VKER_SIZE = 3
) (
  input  logic                 clk,
  input  logic                 vres_n,
  input  logic                 vclrbuffer,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [VKER_SIZE-2:0] vtop,
  output logic [VKER_SIZE-2:0] vout,
  output logic                 sof,
  output logic                 eol,
  output logic                 eof
`ifdef VBORDER_FRAME_CNT_EN
  ,
  output logic [CTR_W-1:0]     frame_cnt
`endif
);

  localparam int P = pad_rows(VKER_SIZE);
  localparam logic [CTR_W-1:0] FILL_ROW = CTR_W'(P - 1);
  localparam logic [CTR_W-1:0] COL_END = HIM_LEN - CTR_W'(1);
  localparam logic [CTR_W-1:0] ROW_END = VIM_LEN - CTR_W'(1);

  state_t state, state_nxt;

  logic             in_hs;
  logic             out_hs;
  logic [CTR_W-1:0] in_col;
  logic [CTR_W-1:0] in_row;
  logic [CTR_W-1:0] out_col;
  logic [CTR_W-1:0] out_row;
  logic             in_lc;
  logic             in_lr;
  logic             out_lc;
  logic             out_lr;

  assign in_hs  = pix_valid & pix_ready;
  assign out_hs = out_valid & out_ready;

  wrap_ctr #(
    .COL_LEN (HIM_LEN),
    .ROW_LEN (VIM_LEN)
  ) u_in_ctr (
    .clk      (clk),
    .rst_n    (vres_n),
    .en       (in_hs),
    .clr      (vclrbuffer),
    .col      (in_col),
    .row      (in_row),
    .last_col (in_lc),
    .last_row (in_lr)
  );

  wrap_ctr #(
    .COL_LEN (HIM_LEN),
    .ROW_LEN (VIM_LEN)
  ) u_out_ctr (
    .clk      (clk),
    .rst_n    (vres_n),
    .en       (out_hs),
    .clr      (vclrbuffer),
    .col      (out_col),
    .row      (out_row),
    .last_col (out_lc),
    .last_row (out_lr)
  );

  always_ff @(posedge clk or negedge vres_n) begin
    if (!vres_n) begin
      state <= FILL;
    end else if (vclrbuffer) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // Transitions use the raw handshake terms of each state.
  always_comb begin
    pix_ready = 1'b0;
    out_valid = 1'b0;
    state_nxt = state;
    unique case (state)
      FILL: begin
        pix_ready = 1'b1;
        if (pix_valid && in_col == COL_END && in_row == FILL_ROW)
          state_nxt = RUN;
      end
      RUN: begin
        pix_ready = out_ready;
        out_valid = pix_valid;
        if (pix_valid && out_ready && in_lc && in_lr)
          state_nxt = FLUSH;
      end
      FLUSH: begin
        out_valid = 1'b1;
        if (out_ready && eof)
          state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  assign sof = (out_row == '0) && (out_col == '0);
  assign eol = out_lc;
  assign eof = out_lc & out_lr;

  always_comb begin
    vtop = '1;
    vout = '1;
    for (int i = 0; i < VKER_SIZE - 1; i++) begin
      if (out_row == CTR_W'(i))
        vtop[i] = 1'b0;
      if (out_row == ROW_END - CTR_W'(i))
        vout[i] = 1'b0;
    end
  end

`ifdef VBORDER_FRAME_CNT_EN
  always_ff @(posedge clk or negedge vres_n) begin
    if (!vres_n) begin
      frame_cnt <= '0;
    end else if (vclrbuffer) begin
      frame_cnt <= '0;
    end else if (out_hs && eof) begin
      frame_cnt <= frame_cnt + CTR_W'(1);
    end
  end
`endif

endmodule
